// File: rtl/vxe_mem_hub_us_arb_pkg.sv
// Shared memory-hub upstream arbiter definitions: client ids, FSM states and
// the round-robin successor helper used by the picker.
package vxe_mem_hub_us_arb_pkg;

   localparam int NUM_CLIENTS = 3;

   typedef logic [1:0] client_id_t;
   typedef logic [2:0] credit_t;
   typedef logic [3:0] burst_t;

   localparam client_id_t CLIENT_CU   = 2'd0;
   localparam client_id_t CLIENT_VPU0 = 2'd1;
   localparam client_id_t CLIENT_VPU1 = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_STALL = 2'd2
   } arb_state_e;

   // Next client in round-robin order, wrapping VPU1 back to CU.
   function automatic client_id_t rr_next(input client_id_t id);
      return (id == CLIENT_VPU1) ? CLIENT_CU : client_id_t'(id + 2'd1);
   endfunction

endpackage

// File: rtl/vxe_mem_hub_us_arb_if.sv
// Request/grant/credit bundle between the memory-hub clients and the
// upstream arbiter; the arbiter takes the slave side.
interface vxe_mem_hub_us_arb_if;
   import vxe_mem_hub_us_arb_pkg::*;

   logic [NUM_CLIENTS-1:0] i_req;
   logic                   i_crd_ret;
   logic [NUM_CLIENTS-1:0] o_gnt;
   client_id_t             o_gnt_id;
   credit_t                o_credits;
   logic                   o_err;

   modport master (
      output i_req, i_crd_ret,
      input  o_gnt, o_gnt_id, o_credits, o_err
   );

   modport slave (
      input  i_req, i_crd_ret,
      output o_gnt, o_gnt_id, o_credits, o_err
   );

endinterface

// File: rtl/vxe_mem_hub_us_arb_rr_pick.sv
// Round-robin picker: searches ptr+1, ptr+2, ptr (mod 3) and returns the
// first requester as a one-hot vector plus its encoded id.
module vxe_mem_hub_rr_pick
   import vxe_mem_hub_us_arb_pkg::*;
(
   input  client_id_t             ptr,
   input  logic [NUM_CLIENTS-1:0] req,
   output logic [NUM_CLIENTS-1:0] gnt,
   output client_id_t             gnt_id
);

   client_id_t cand;
   logic       found;

   always_comb begin
      gnt    = '0;
      gnt_id = CLIENT_CU;
      found  = 1'b0;
      cand   = ptr;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         cand = rr_next(cand);
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            gnt_id    = cand;
         end
      end
   end

endmodule

// File: rtl/vxe_mem_hub_us_arb.sv
// Credit-gated round-robin upstream arbiter for the memory hub: registered
// one-hot grant, per-client burst limit, sticky credit over-return error.
module vxe_mem_hub_us_arb
   import vxe_mem_hub_us_arb_pkg::*;
#(
   parameter int CREDITS   = 4,
   parameter int MAX_BURST = 4
) (
   input logic                 clk,
   input logic                 rst,
   vxe_mem_hub_us_arb_if.slave bus
);

   localparam credit_t CRD_MAX   = credit_t'(CREDITS);
   localparam burst_t  BURST_MAX = burst_t'(MAX_BURST);

   arb_state_e             state_q, state_d;
   logic [NUM_CLIENTS-1:0] gnt_q, gnt_d, pick_gnt;
   client_id_t             gnt_id_q, gnt_id_d, last_q, last_d, pick_id;
   credit_t                credits_q, credits_d;
   burst_t                 burst_q, burst_d, burst_after;
   logic                   err_q, err_d;
   logic                   transfer, any_req, over_ret, crd_avail, hold, start;

   assign transfer    = |(gnt_q & bus.i_req);
   assign any_req     = |bus.i_req;
   assign over_ret    = bus.i_crd_ret && !transfer && (credits_q == CRD_MAX);
   assign credits_d   = over_ret ? credits_q
                                 : credits_q + credit_t'(bus.i_crd_ret) - credit_t'(transfer);
   assign err_d       = err_q | over_ret;
   assign crd_avail   = (credits_d != '0);
   assign burst_after = burst_q + burst_t'(transfer);
   assign hold        = bus.i_req[gnt_id_q] && (burst_after < BURST_MAX) && crd_avail;

   vxe_mem_hub_rr_pick u_pick (
      .ptr    (last_q),
      .req    (bus.i_req),
      .gnt    (pick_gnt),
      .gnt_id (pick_id)
   );

   // NOTE: every signal written here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      gnt_d    = '0;
      gnt_id_d = CLIENT_CU;
      last_d   = last_q;
      burst_d  = burst_q;
      start    = 1'b0;
      unique case (state_q)
         ST_GRANT: begin
            if (hold) begin
               gnt_d    = gnt_q;
               gnt_id_d = gnt_id_q;
               burst_d  = burst_after;
            end else if (!crd_avail) begin
               state_d = ST_STALL;
            end else if (any_req) begin
               // Picking from last_q == current client covers both hand-off
               // to another requester and re-grant after a burst limit.
               start = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_STALL: begin
            if (!any_req)       state_d = ST_IDLE;
            else if (crd_avail) start   = 1'b1;
         end
         default: begin
            if (any_req && crd_avail) start = 1'b1;
         end
      endcase
      if (start) begin
         state_d  = ST_GRANT;
         gnt_d    = pick_gnt;
         gnt_id_d = pick_id;
         last_d   = pick_id;
         burst_d  = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         gnt_q     <= '0;
         gnt_id_q  <= CLIENT_CU;
         last_q    <= CLIENT_VPU1;
         credits_q <= CRD_MAX;
         burst_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         last_q    <= last_d;
         credits_q <= credits_d;
         burst_q   <= burst_d;
         err_q     <= err_d;
      end
   end

   assign bus.o_gnt     = gnt_q;
   assign bus.o_gnt_id  = gnt_id_q;
   assign bus.o_credits = credits_q;
   assign bus.o_err     = err_q;

endmodule

// File: doc/vxe_mem_hub_us_arb.md
VXE_MEM_HUB_US_ARB -- requirements
Module: vxe_mem_hub_us_arb

Interface
REQ-001 SHALL have parameter CREDITS, default 4: downstream slots (master-port address FIFO depth), legal range 1..7.
REQ-002 SHALL have parameter MAX_BURST, default 4: max consecutive transfers granted to one client before forced rotation, legal range 1..15.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_req  input  3  per-client request pending; bit0=CU, bit1=VPU0, bit2=VPU1.
REQ-006 SHALL have port i_crd_ret  input  1  one downstream slot freed this cycle.
REQ-007 SHALL have port o_gnt  output  3  registered one-hot grant, or all zero.
REQ-008 SHALL have port o_gnt_id  output  2  encoded grant (0/1/2), valid when o_gnt!=0.
REQ-009 SHALL have port o_credits  output  3  current credit count.
REQ-010 SHALL have port o_err  output  1  sticky: credit over-return.

Function
REQ-011 A transfer SHALL occur in a cycle iff o_gnt[k] && i_req[k]; exactly one transfer per such cycle.
REQ-012 Credits SHALL update as credits + i_crd_ret - transfer; simultaneous return and transfer SHALL leave credits unchanged.
REQ-013 A return with credits==CREDITS and no transfer SHALL hold credits at CREDITS and set o_err.
REQ-014 States SHALL be IDLE (no grant), GRANT (o_gnt one-hot), STALL (no grant, credits exhausted).
REQ-015 Grant latency SHALL be one cycle: a request sampled in cycle N with credits available yields o_gnt in N+1.
REQ-016 Priority SHALL be round-robin from last-granted pointer L: order L+1, L+2, L (mod 3).
REQ-017 IDLE: if any i_req and next credits>0, go to GRANT for highest-priority requester, clear burst counter; else stay.
REQ-018 GRANT holds client g iff i_req[g], burst count after this cycle < MAX_BURST, and next credits>0; burst counter increments per transfer.
REQ-019 GRANT losing hold: next credits==0 -> STALL; else other requester pending -> re-arbitrate per REQ-016 with L=g; else i_req[g] and burst limit hit -> re-grant g with counter cleared; else IDLE.
REQ-020 STALL SHALL exit when next credits>0, arbitrating per REQ-016 (L preserved), or to IDLE if no request.
REQ-021 o_gnt SHALL never be nonzero while o_credits==0.
REQ-022 Grant SHALL drop one cycle after requester deasserts i_req; no transfer in the deassert cycle.
REQ-023 Any client continuously requesting SHALL be granted within 2*MAX_BURST+2 cycles (no starvation).

Reset
REQ-024 On rst: o_gnt=0, o_gnt_id=0, o_credits=CREDITS, o_err=0, state IDLE, burst counter 0, L=VPU1 (CU highest first).
REQ-025 rst mid-transfer SHALL override all other updates that cycle; in-flight credits are forgotten.

Structure
REQ-026 Client ID constants (CU=0, VPU0=1, VPU1=2) and FSM state encodings SHALL live in the shared mem_hub package.
REQ-027 Round-robin next-grant selection SHALL be one combinational sub-module, vxe_mem_hub_rr_pick (pointer + request vector -> one-hot + id).

Verification
REQ-028 Reset then i_req=001 held, no returns -> o_gnt=001 from cycle 1, 4 transfers, then STALL, o_credits=0.
REQ-029 i_req=111 held, i_crd_ret=1 every cycle -> grants rotate 001(x4),010(x4),100(x4), repeating; credits constant at 4.
REQ-030 credits=1, transfer plus i_crd_ret same cycle -> credits stays 1, grant continues.
REQ-031 Idle, credits=4, i_crd_ret=1 -> o_credits=4, o_err=1 and sticky until rst.
REQ-032 Grant 010 active, i_req[1] drops in cycle N -> o_gnt=000 (or next client) in N+1, no credit consumed in N.
REQ-033 STALL with i_req=110, L=CU, one return -> next o_gnt=010 after return cycle.
